uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver, 8N1 frames, LSB first, on a single serial input `rx`.
- The last correctly framed byte is held on `data` until the next good byte arrives.
- Sits at the top of the serial input path; the parallel byte feeds downstream display/level logic.
- Adds `valid` and `frame_err` status strobes for consumers that need them.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (10416), clock cycles per bit; must be ≥ 8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- data  out  8  last good received byte.
- valid  out  1  one-cycle pulse when `data` is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: data=8'h00, valid=0, frame_err=0. FSM goes to IDLE; bit counter and baud counter are 0. `rx` synchronizer flops reset to 1.
- Synchronization: `rx` passes through a 2-flop synchronizer giving `rx_s`. All decisions use `rx_s`.
- Baud counter counts 0..CLKS_PER_BIT-1. Half-bit point is CLKS_PER_BIT/2 (integer division).
- IDLE:
  - On `rx_s`=0, go to START and clear the baud counter.
- START:
  - At half-bit, if `rx_s`=0, the start is confirmed: clear the baud counter and bit index, go to DATA.
  - If `rx_s`=1 at half-bit, it is a false start: return to IDLE with no output change.
- DATA:
  - At each full CLKS_PER_BIT from the confirmed start mid-point, sample `rx_s` into shift[bit_idx], LSB first.
  - After bit 7, go to STOP.
- STOP: after one more full bit period, sample `rx_s`.
  - If 1: data<=shift, valid=1 for exactly one cycle, go to IDLE.
  - If 0: frame_err=1 for one cycle, `data` unchanged, go to BREAK.
- BREAK:
  - Wait for `rx_s`=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Timing:
  - Each sample is taken at bit centre, about 1.5 bit periods after the start edge for bit 0, plus 2 synchronizer cycles.
  - `data` and `valid` change at the stop-bit centre + 2 cycles.
  - Tolerates ±2% bit-period skew and jitter of a few ns per edge.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after STOP. No minimum idle gap is required.
- Reset mid-frame: the frame is abandoned immediately, `data` is cleared to 0, and no `valid` is produced.
- `valid` and `frame_err` are never asserted in the same cycle.

Optional Feature:
- Macro RX_MAJORITY_EN.
- When defined, each start, data and stop sample is a 2-of-3 majority vote of `rx_s` taken at half-bit-1, half-bit and half-bit+1. For data and stop bits these offsets are relative to the bit centre.
- When undefined, a single sample is taken at the centre.
- Timing of `data`/`valid` is identical in both builds, except the majority build commits 1 cycle later.

Test Plan:
- Reset, then hold `rx` high for 5 bit times → data=8'h00, no valid, no frame_err.
- Send bits LSB-first 1,0,0,1,1,0,1,0 + stop 1, with per-bit period 104166 ns ±4 ns → data=8'h59, one valid pulse.
- Immediately send 0,1,0,1,1,1,0,1 → data=8'hBA; then 1,1,1,1,1,1,0,1 with bit period −4 ns → data=8'hBF.
- Repeat the 0x59/0xBA/0xBF sequence, then send 0x59 after a 15-bit idle gap → each byte is received correctly in order; exactly one valid pulse per frame.
- Send a frame 0xA5 with the stop bit low, followed by 2 bit times low → frame_err pulse once, data keeps its previous value, then the next frame 0x3C is received correctly.
- Pull `rx` low for 0.3 bit then back high → no reception (false start). Separately, assert `rst` during bit 4 of a frame → data=8'h00 and the FSM resumes cleanly on the next frame.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- 8N1 UART receiver, LSB first.
//
// The line is synchronised, a start bit is confirmed at its centre and the
// eight data bits and the stop bit are sampled at their centres. A good stop
// bit commits the byte to `data` with a one-cycle `valid` pulse. A low stop
// bit produces a one-cycle `frame_err` pulse and leaves `data` untouched.
// After a framing error the receiver waits for the line to return high
// before it looks for a new start bit.
//
// Build option: define RX_MAJORITY_EN to take every start/data/stop sample
// as a 2-of-3 vote over centre-1, centre and centre+1. That build commits
// one cycle later than the single-sample build.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   data       out  [7:0] last correctly framed byte
//   valid      out  one-cycle pulse when `data` is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//
// CLKS_PER_BIT must be at least 8.

module uart_rx_byte #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

  // With voting, the decision is made on the last of the three votes, one
  // cycle after the centre. Clearing the counter at that point keeps every
  // later decision on the same one-cycle-late grid, so the data/stop
  // decision point is CLKS_PER_BIT-1 in both builds.
`ifdef RX_MAJORITY_EN
  localparam int START_DEC = HALF_BIT + 1;
`else
  localparam int START_DEC = HALF_BIT;
`endif

  localparam logic [CNT_W-1:0] START_DEC_C = CNT_W'(START_DEC);
  localparam logic [CNT_W-1:0] BIT_END_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic             rx_meta_q;
  logic             rx_sync_q;
  logic             rx_s;
  logic             sample_s;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;

  assign rx_s = rx_sync_q;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef RX_MAJORITY_EN
  logic [1:0] hist_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-deep history of rx_s: at a decision cycle it holds the votes taken
  // one and two cycles earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign sample_s = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample_s = rx_s;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: start detection, bit sampling and frame commit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == START_DEC_C) begin
          cnt_d = CNT_ZERO;
          if (!sample_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Glitch shorter than half a bit: not a start bit.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_END_C) begin
          cnt_d              = CNT_ZERO;
          shift_d[bit_idx_q] = sample_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_END_C) begin
          cnt_d = CNT_ZERO;
          if (sample_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        // A held-low line must not look like a stream of start bits.
        cnt_d = CNT_ZERO;
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: 32 clocks per bit (10-unit clock, 320-unit bit).

module tb_uart_rx_byte;

  localparam int CPB   = 32;
  localparam int BIT_T = CPB * 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int both_cnt  = 0;

  typedef struct {
    logic [7:0] tx_byte;
    logic       stop_bit;
    int         adj;
    logic       jit;
    int         gap_bits;
    int         low_after;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [0:8];

  always #5 clk = ~clk;

  uart_rx_byte #(
    .CLK_FREQ_HZ(320000),
    .BAUD       (10000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err)
  );

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid)             valid_cnt <= valid_cnt + 1;
    if (frame_err)         ferr_cnt  <= ferr_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit. rx is left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input int adj, input logic jit);
    for (int k = 0; k < 10; k++) begin
      int p;
      if (jit) p = BIT_T + (((k % 2) != 0) ? 5 : -5);
      else     p = BIT_T + adj;
      if (k == 0)      rx = 1'b0;
      else if (k == 9) rx = stop_b;
      else             rx = b[k-1];
      #(p);
    end
  endtask

  initial begin
    int vb;
    int fb;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data", data, 8'h00);
    check("reset valid", valid, 0);
    check("reset frame_err", frame_err, 0);
    rst = 1'b0;

    // Idle line for 5 bit times.
    #(5 * BIT_T);
    @(negedge clk);
    check("idle data", data, 8'h00);
    check("idle valid count", valid_cnt, 0);
    check("idle ferr count", ferr_cnt, 0);

    //           byte   stop  adj jit  gap low  exp    v  f
    vecs[0] = '{8'h59, 1'b1,  0, 1'b1,  1, 0, 8'h59, 1, 0};
    vecs[1] = '{8'hBA, 1'b1,  0, 1'b0,  0, 0, 8'hBA, 1, 0};
    vecs[2] = '{8'hBF, 1'b1, -5, 1'b0,  0, 0, 8'hBF, 1, 0};
    vecs[3] = '{8'h59, 1'b1,  5, 1'b0,  0, 0, 8'h59, 1, 0};
    vecs[4] = '{8'hBA, 1'b1,  0, 1'b1,  0, 0, 8'hBA, 1, 0};
    vecs[5] = '{8'hBF, 1'b1, -5, 1'b0,  0, 0, 8'hBF, 1, 0};
    vecs[6] = '{8'h59, 1'b1,  0, 1'b0, 15, 0, 8'h59, 1, 0};
    vecs[7] = '{8'hA5, 1'b0,  0, 1'b0,  0, 2, 8'h59, 0, 1};
    vecs[8] = '{8'h3C, 1'b1,  0, 1'b0,  1, 0, 8'h3C, 1, 0};

    for (int i = 0; i < 9; i++) begin
      vb = valid_cnt;
      fb = ferr_cnt;
      rx = 1'b1;
      #(vecs[i].gap_bits * BIT_T);
      send_frame(vecs[i].tx_byte, vecs[i].stop_bit, vecs[i].adj, vecs[i].jit);
      if (vecs[i].low_after > 0) begin
        #(vecs[i].low_after * BIT_T);
        rx = 1'b1;
      end
      @(negedge clk);
      check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d valid pulses", i), valid_cnt - vb, vecs[i].exp_valid);
      check($sformatf("vec%0d ferr pulses", i), ferr_cnt - fb, vecs[i].exp_ferr);
    end

    // False start: 0.3 bit low pulse.
    vb = valid_cnt;
    fb = ferr_cnt;
    rx = 1'b0;
    #(BIT_T * 3 / 10);
    rx = 1'b1;
    #(2 * BIT_T);
    @(negedge clk);
    check("false start data", data, 8'h3C);
    check("false start valid", valid_cnt - vb, 0);
    check("false start ferr", ferr_cnt - fb, 0);

    // Reset in the middle of bit 4 of frame 0xF0 (bits 4..7 and stop high).
    vb = valid_cnt;
    fb = ferr_cnt;
    fork
      send_frame(8'hF0, 1'b1, 0, 1'b0);
      begin
        #(BIT_T * 11 / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midframe reset data", data, 8'h00);
      end
    join
    rx = 1'b1;
    #(BIT_T);
    @(negedge clk);
    check("after reset data", data, 8'h00);
    check("after reset valid", valid_cnt - vb, 0);
    check("after reset ferr", ferr_cnt - fb, 0);

    // Recovery frame after the reset.
    vb = valid_cnt;
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("recover data", data, 8'h3C);
    check("recover valid", valid_cnt - vb, 1);

    check("valid with frame_err", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
